// File: rtl/coef_update_sched.sv
// ---------------------------------------------------------------------------
// coef_update_sched
//
// Schedules host coefficient writes into the DSP core coefficient RAM so that
// an audio frame never sees a half-applied update. Host entries arrive as
// atomic groups (the final entry carries wr_last) and are buffered in a small
// FIFO. A complete group is committed back-to-back only while the DSP core is
// idle. The frame-start pulse is routed through this block and held back
// while a group is being committed, so every frame sees all or none of it.
//
// Optional feature: define COEF_UPDATE_SCHED_STATS_EN to enable the
// groups_applied / starts_deferred saturating counters. Without it both
// ports are tied to zero.
//
// Ports:
//   clk             oversampling bit clock
//   rst             asynchronous, active-low reset
//   wr_valid        host entry valid
//   wr_ready        FIFO can accept (registered, = not full)
//   wr_addr         coefficient address
//   wr_data         coefficient value
//   wr_last         entry closes a group
//   start_in        frame-start pulse from the ADAT output framer
//   dsp_busy        DSP core is processing a frame
//   start_out       frame-start pulse to the DSP core (registered)
//   coef_we         coefficient RAM write strobe (registered)
//   coef_addr       coefficient RAM write address (registered)
//   coef_data       coefficient RAM write data (registered)
//   start_overrun   sticky: start_in arrived while a start was still pending
//   group_overflow  sticky: FIFO filled without a complete group, FIFO flushed
//   groups_applied  committed-group counter (stats build only, else 0)
//   starts_deferred starts held back by a commit (stats build only, else 0)
// ---------------------------------------------------------------------------
module coef_update_sched #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              start_in,
  input  logic              dsp_busy,
  output logic              start_out,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [DATA_W-1:0] coef_data,
  output logic              start_overrun,
  output logic              group_overflow,
  output logic [15:0]       groups_applied,
  output logic [15:0]       starts_deferred
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  group_cnt_q, group_cnt_d;
  logic              wr_ready_q, wr_ready_d;
  logic              discard_q, discard_d;
  logic              start_pend_q, start_pend_d;
  logic [1:0]        guard_q, guard_d;
  logic              start_out_q, start_out_d;
  logic              coef_we_q, coef_we_d;
  logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
  logic [DATA_W-1:0] coef_data_q, coef_data_d;
  logic              start_overrun_q, start_overrun_d;
  logic              group_overflow_q, group_overflow_d;

  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              overflow_s;
  logic              fire_s;
  logic [ENT_W-1:0]  head_s;
  logic              head_last_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  assign head_s      = mem_q[rd_ptr_q];
  assign head_last_s = head_s[ENT_W-1];
  assign head_addr_s = head_s[ADDR_W+DATA_W-1:DATA_W];
  assign head_data_s = head_s[DATA_W-1:0];

  // Handshake completes even while discarding, so the host keeps flowing.
  assign accept_s   = wr_valid && wr_ready_q;
  // A full FIFO holding no complete group can never commit: the group is too long.
  assign overflow_s = (count_q == CNT_W'(DEPTH)) && (group_cnt_q == {CNT_W{1'b0}});
  assign push_s     = accept_s && !discard_q && !overflow_s;
  assign pop_s      = (state_q == ST_APPLY) && (count_q != {CNT_W{1'b0}});

  // FIFO storage write port; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {wr_last, wr_addr, wr_data};
    end
  end

  // FIFO pointers, occupancy, complete-group count and overflow discard tracking
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    group_cnt_d      = group_cnt_q;
    discard_d        = discard_q;
    group_overflow_d = group_overflow_q;
    if (overflow_s) begin
      wr_ptr_d         = {PTR_W{1'b0}};
      rd_ptr_d         = {PTR_W{1'b0}};
      count_d          = {CNT_W{1'b0}};
      discard_d        = 1'b1;
      group_overflow_d = 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      case ({push_s && wr_last, pop_s && head_last_s})
        2'b10:   group_cnt_d = group_cnt_q + CNT_W'(1);
        2'b01:   group_cnt_d = group_cnt_q - CNT_W'(1);
        default: group_cnt_d = group_cnt_q;
      endcase
      // The tail of an oversized group is dropped through its closing entry.
      if (accept_s && discard_q && wr_last) begin
        discard_d = 1'b0;
      end else begin
        discard_d = discard_q;
      end
    end
    // Ready reflects occupancy after this cycle, so a pop frees the slot next cycle.
    wr_ready_d = (count_d != CNT_W'(DEPTH));
  end

  // Scheduler: start forwarding (priority), commit entry, write strobes, guard
  always_comb begin
    state_d         = state_q;
    fire_s          = 1'b0;
    start_pend_d    = start_pend_q;
    start_overrun_d = start_overrun_q;
    guard_d         = guard_q;
    coef_we_d       = 1'b0;
    coef_addr_d     = coef_addr_q;
    coef_data_d     = coef_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_pend_q || start_in) begin
          fire_s  = 1'b1;
          state_d = ST_IDLE;
        end else if ((group_cnt_q != {CNT_W{1'b0}}) && !dsp_busy && (guard_q == 2'd0)) begin
          state_d = ST_APPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        // dsp_busy is deliberately ignored here: a started group always finishes.
        if (pop_s && head_last_s) begin
          state_d = ST_IDLE;
        end else if (!pop_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fire_s) begin
      start_pend_d = 1'b0;
    end else if (start_in) begin
      start_pend_d = 1'b1;
    end else begin
      start_pend_d = start_pend_q;
    end

    if (start_in && start_pend_q && !fire_s) begin
      start_overrun_d = 1'b1;
    end else begin
      start_overrun_d = start_overrun_q;
    end

    // Guard bridges the gap before the DSP core reflects the new frame on dsp_busy.
    if (fire_s) begin
      guard_d = 2'd2;
    end else if (guard_q != 2'd0) begin
      guard_d = guard_q - 2'd1;
    end else begin
      guard_d = 2'd0;
    end

    if (pop_s) begin
      coef_we_d   = 1'b1;
      coef_addr_d = head_addr_s;
      coef_data_d = head_data_s;
    end else begin
      coef_we_d   = 1'b0;
      coef_addr_d = coef_addr_q;
      coef_data_d = coef_data_q;
    end
  end

  assign start_out_d = fire_s;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      wr_ptr_q         <= {PTR_W{1'b0}};
      rd_ptr_q         <= {PTR_W{1'b0}};
      count_q          <= {CNT_W{1'b0}};
      group_cnt_q      <= {CNT_W{1'b0}};
      wr_ready_q       <= 1'b1;
      discard_q        <= 1'b0;
      start_pend_q     <= 1'b0;
      guard_q          <= 2'd0;
      start_out_q      <= 1'b0;
      coef_we_q        <= 1'b0;
      coef_addr_q      <= {ADDR_W{1'b0}};
      coef_data_q      <= {DATA_W{1'b0}};
      start_overrun_q  <= 1'b0;
      group_overflow_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      group_cnt_q      <= group_cnt_d;
      wr_ready_q       <= wr_ready_d;
      discard_q        <= discard_d;
      start_pend_q     <= start_pend_d;
      guard_q          <= guard_d;
      start_out_q      <= start_out_d;
      coef_we_q        <= coef_we_d;
      coef_addr_q      <= coef_addr_d;
      coef_data_q      <= coef_data_d;
      start_overrun_q  <= start_overrun_d;
      group_overflow_q <= group_overflow_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign start_out      = start_out_q;
  assign coef_we        = coef_we_q;
  assign coef_addr      = coef_addr_q;
  assign coef_data      = coef_data_q;
  assign start_overrun  = start_overrun_q;
  assign group_overflow = group_overflow_q;

`ifdef COEF_UPDATE_SCHED_STATS_EN
  logic [15:0] groups_applied_q, groups_applied_d;
  logic [15:0] starts_deferred_q, starts_deferred_d;

  // Saturating statistics counters
  always_comb begin
    groups_applied_d  = groups_applied_q;
    starts_deferred_d = starts_deferred_q;
    if (pop_s && head_last_s && (groups_applied_q != 16'hFFFF)) begin
      groups_applied_d = groups_applied_q + 16'd1;
    end else begin
      groups_applied_d = groups_applied_q;
    end
    if ((state_q == ST_APPLY) && start_in && (starts_deferred_q != 16'hFFFF)) begin
      starts_deferred_d = starts_deferred_q + 16'd1;
    end else begin
      starts_deferred_d = starts_deferred_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      groups_applied_q  <= 16'd0;
      starts_deferred_q <= 16'd0;
    end else begin
      groups_applied_q  <= groups_applied_d;
      starts_deferred_q <= starts_deferred_d;
    end
  end

  assign groups_applied  = groups_applied_q;
  assign starts_deferred = starts_deferred_q;
`else
  assign groups_applied  = 16'h0000;
  assign starts_deferred = 16'h0000;
`endif

endmodule

// File: tb/tb_coef_update_sched.sv
// ---------------------------------------------------------------------------
// Testbench for coef_update_sched. Stimulus pushes expected RAM writes into a
// scoreboard queue; an independent monitor pops and compares on every coef_we.
// ---------------------------------------------------------------------------
module tb_coef_update_sched;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 36;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_last = 1'b0;
  logic              start_in = 1'b0;
  logic              dsp_busy = 1'b0;
  logic              start_out;
  logic              coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              start_overrun;
  logic              group_overflow;
  logic [15:0]       groups_applied;
  logic [15:0]       starts_deferred;

  coef_update_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last),
    .start_in(start_in), .dsp_busy(dsp_busy), .start_out(start_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start_overrun(start_overrun), .group_overflow(group_overflow),
    .groups_applied(groups_applied), .starts_deferred(starts_deferred)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  we_cyc_q[$];
  int  cyc = 0;
  int  so_cnt = 0;
  int  so_cyc = 0;
  int  ready_low = 0;
  int  vec_cnt = 0;
  int  err_cnt = 0;
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare of every RAM write, plus start_out bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      if (!wr_ready) ready_low++;
      if (coef_we) begin
        we_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", coef_addr, coef_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(coef_addr), 64'(mon_e.addr));
          check("wr_data", 64'(coef_data), 64'(mon_e.data));
        end
      end
      if (start_out) begin
        so_cnt++;
        so_cyc = cyc;
      end
    end
  end

  task automatic push(input int a, input longint d, input logic last, input logic expect_wr);
    bit  ok;
    wr_t e;
    ok       = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = DATA_W'(d);
    wr_last  = last;
    for (int t = 0; t < 200; t++) begin
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      if (expect_wr) begin
        e.addr = ADDR_W'(a);
        e.data = DATA_W'(d);
        exp_q.push_back(e);
      end
      @(negedge clk);
    end else begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL push_timeout: got wr_ready 0 for 200 cycles, expected 1");
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_we();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (coef_we) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL wait_we_timeout: got no coef_we in 100 cycles, expected a write");
    end
  endtask

  function automatic int wr_span(input int base, input int n);
    if (we_cyc_q.size() >= base + n) return we_cyc_q[base+n-1] - we_cyc_q[base];
    else return -1;
  endfunction

  function automatic int wr_at(input int idx);
    if (we_cyc_q.size() > idx) return we_cyc_q[idx];
    else return -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int so0;
    int nf;
    int rl0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_start_out", 64'(start_out), 64'd0);
    check("rst_coef_we", 64'(coef_we), 64'd0);
    check("rst_coef_addr", 64'(coef_addr), 64'd0);
    check("rst_coef_data", 64'(coef_data), 64'd0);
    check("rst_overrun", 64'(start_overrun), 64'd0);
    check("rst_overflow", 64'(group_overflow), 64'd0);
    check("rst_stats", 64'({groups_applied, starts_deferred}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // T1: 3-entry group, DSP idle
    base = we_cyc_q.size();
    rl0  = ready_low;
    push(5, 1, 1'b0, 1'b1);
    push(6, 2, 1'b0, 1'b1);
    push(7, 3, 1'b1, 1'b1);
    drain("t1_drain");
    check("t1_writes", 64'(we_cyc_q.size() - base), 64'd3);
    check("t1_back_to_back", 64'(wr_span(base, 3)), 64'd2);
    check("t1_ready_high", 64'(ready_low - rl0), 64'd0);

    // T2: same shape while DSP busy for 20 cycles
    dsp_busy = 1'b1;
    base = we_cyc_q.size();
    push(10, 64'hA, 1'b0, 1'b1);
    push(11, 64'hB, 1'b0, 1'b1);
    push(12, 64'hC, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_no_write_busy", 64'(we_cyc_q.size() - base), 64'd0);
    dsp_busy = 1'b0;
    nf = cyc;
    drain("t2_drain");
    check("t2_first_write_cyc", 64'(wr_at(base)), 64'(nf + 2));
    check("t2_back_to_back", 64'(wr_span(base, 3)), 64'd2);

    // T3: 8-entry group, start_in during the second write cycle
    base = we_cyc_q.size();
    so0  = so_cnt;
    for (int i = 0; i < 8; i++) push(32 + i, 256 + i, (i == 7), 1'b1);
    wait_we();
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    drain("t3_drain");
    check("t3_writes", 64'(we_cyc_q.size() - base), 64'd8);
    check("t3_back_to_back", 64'(wr_span(base, 8)), 64'd7);
    check("t3_single_start", 64'(so_cnt - so0), 64'd1);
    check("t3_start_after_last", 64'(so_cyc), 64'(wr_at(base + 7) + 1));
    check("t3_no_overrun", 64'(start_overrun), 64'd0);
`ifdef COEF_UPDATE_SCHED_STATS_EN
    check("t3_starts_deferred", 64'(starts_deferred), 64'd1);
    check("t3_groups_applied", 64'(groups_applied), 64'd3);
`else
    check("t3_stats_tied_off", 64'({groups_applied, starts_deferred}), 64'd0);
`endif

    // T4: start_in and ready group in the same IDLE cycle
    dsp_busy = 1'b1;
    push(20, 64'h14, 1'b0, 1'b1);
    push(21, 64'h15, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    base = we_cyc_q.size();
    so0  = so_cnt;
    dsp_busy = 1'b0;
    start_in = 1'b1;
    @(negedge clk);
    check("t4_start_out_next", 64'(start_out), 64'd1);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_no_write_guard", 64'(we_cyc_q.size() - base), 64'd0);
    dsp_busy = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_no_write_busy", 64'(we_cyc_q.size() - base), 64'd0);
    dsp_busy = 1'b0;
    nf = cyc;
    drain("t4_drain");
    check("t4_first_write_cyc", 64'(wr_at(base)), 64'(nf + 2));
    check("t4_single_start", 64'(so_cnt - so0), 64'd1);

    // T5: 9 entries without wr_last overflow the FIFO
    base = we_cyc_q.size();
    for (int i = 0; i < 9; i++) push(100 + i, i, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_overflow", 64'(group_overflow), 64'd1);
    check("t5_no_write", 64'(we_cyc_q.size() - base), 64'd0);
    push(109, 9, 1'b1, 1'b0);
    push(30, 64'h1E, 1'b0, 1'b1);
    push(31, 64'h1F, 1'b1, 1'b1);
    drain("t5_drain");
    check("t5_writes", 64'(we_cyc_q.size() - base), 64'd2);
    check("t5_overflow_sticky", 64'(group_overflow), 64'd1);
    check("t5_ready", 64'(wr_ready), 64'd1);

    // T6: two start_in pulses during one APPLY
    base = we_cyc_q.size();
    so0  = so_cnt;
    for (int i = 0; i < 4; i++) push(40 + i, 64'h40 + i, (i == 3), 1'b1);
    wait_we();
    start_in = 1'b1;
    repeat (2) @(negedge clk);
    start_in = 1'b0;
    drain("t6_drain");
    check("t6_overrun", 64'(start_overrun), 64'd1);
    check("t6_single_start", 64'(so_cnt - so0), 64'd1);
    check("t6_start_after_last", 64'(so_cyc), 64'(wr_at(base + 3) + 1));

    // T7: reset in the middle of APPLY
    for (int i = 0; i < 6; i++) push(50 + i, 64'h50 + i, (i == 5), 1'b1);
    wait_we();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t7_coef_we", 64'(coef_we), 64'd0);
    check("t7_coef_addr", 64'(coef_addr), 64'd0);
    check("t7_coef_data", 64'(coef_data), 64'd0);
    check("t7_start_out", 64'(start_out), 64'd0);
    check("t7_wr_ready", 64'(wr_ready), 64'd1);
    check("t7_flags", 64'({start_overrun, group_overflow}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = we_cyc_q.size();
    push(60, 64'h3C, 1'b1, 1'b1);
    drain("t7_post_reset_drain");
    check("t7_post_reset_writes", 64'(we_cyc_q.size() - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
